// File: rtl/fpu_norm_sequencer.sv
// Iterative normalizer for the FPU add/FMA back end: applies the LZA-predicted
// left shift in STEP-sized chunks, then fixes up one bit per cycle.
module fpu_norm_sequencer #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_sum,
  input  logic [8:0]  in_exp,
  input  logic        in_guard,
  input  logic        in_round,
  input  logic        in_sticky,
  input  logic [5:0]  in_lza,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_sum,
  output logic [8:0]  out_exp,
  output logic        out_guard,
  output logic        out_round,
  output logic        out_sticky,
  output logic        out_zero,
  output logic [1:0]  out_corr,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRED  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [5:0] STEP_V = 6'(STEP);

  state_t      state, state_nxt;
  logic [49:0] x_q, x_nxt, x_load;
  logic [8:0]  exp_q, exp_nxt;
  logic [5:0]  rem_q, rem_nxt, lza_clamp, step_amt;
  logic [1:0]  corr_q, corr_nxt;
  logic        sticky_q, sticky_nxt, zero_q, zero_nxt;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Input side is ready only in IDLE; output side is valid only in DONE and
  // everything it presents is held until out_ready is seen.
  always_comb begin
    state_nxt  = state;
    x_nxt      = x_q;
    exp_nxt    = exp_q;
    rem_nxt    = rem_q;
    corr_nxt   = corr_q;
    sticky_nxt = sticky_q;
    zero_nxt   = zero_q;
    x_load     = {in_sum, in_guard, in_round};
    lza_clamp  = (in_lza > 6'd47) ? 6'd47 : in_lza;
    step_amt   = (rem_q < STEP_V) ? rem_q : STEP_V;

    case (state)
      IDLE: begin
        if (in_valid) begin
          x_nxt      = x_load;
          exp_nxt    = in_exp;
          sticky_nxt = in_sticky;
          rem_nxt    = lza_clamp;
          corr_nxt   = 2'd0;
          zero_nxt   = (x_load == 50'd0);
          if (x_load == 50'd0)       state_nxt = DONE;
          else if (lza_clamp == 6'd0) state_nxt = CHECK;
          else                        state_nxt = PRED;
        end
      end
      PRED: begin
        x_nxt   = x_q << step_amt;
        exp_nxt = exp_q - {3'b000, step_amt};
        rem_nxt = rem_q - step_amt;
        if (rem_q == step_amt) state_nxt = CHECK;
      end
      CHECK: begin
        if (x_q[49]) begin
          state_nxt = DONE;
        end else begin
          x_nxt    = x_q << 1;
          exp_nxt  = exp_q - 9'd1;
          corr_nxt = (corr_q == 2'd3) ? 2'd3 : corr_q + 2'd1;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      x_q      <= '0;
      exp_q    <= '0;
      rem_q    <= '0;
      corr_q   <= '0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      x_q      <= x_nxt;
      exp_q    <= exp_nxt;
      rem_q    <= rem_nxt;
      corr_q   <= corr_nxt;
      sticky_q <= sticky_nxt;
      zero_q   <= zero_nxt;
    end
  end

  // in_ready is forced low while reset is asserted, even though state is IDLE.
  assign in_ready   = (state == IDLE) && !rst;
  assign out_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign dbg_state  = state;
  assign out_sum    = x_q[49:2];
  assign out_guard  = x_q[1];
  assign out_round  = x_q[0];
  assign out_sticky = sticky_q;
  assign out_exp    = exp_q;
  assign out_zero   = zero_q;
  assign out_corr   = corr_q;

endmodule

// File: tb/tb_fpu_norm_sequencer.sv
// Directed bench for fpu_norm_sequencer: hand-computed vectors, latency,
// backpressure and mid-operation reset.
module tb_fpu_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] in_sum;
  logic [8:0]  in_exp;
  logic        in_guard, in_round, in_sticky;
  logic [5:0]  in_lza;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] out_sum;
  logic [8:0]  out_exp;
  logic        out_guard, out_round, out_sticky, out_zero;
  logic [1:0]  out_corr;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [62:0] exp_q[$];

  // clock / reset-free clock generator
  always #5 clk = ~clk;

  fpu_norm_sequencer #(.STEP(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_exp(in_exp),
    .in_guard(in_guard), .in_round(in_round), .in_sticky(in_sticky),
    .in_lza(in_lza),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_exp(out_exp),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky),
    .out_zero(out_zero), .out_corr(out_corr),
    .busy(busy), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [62:0] pack(input logic [47:0] s, input logic [8:0] e,
                                       input logic g, input logic r, input logic st,
                                       input logic z, input logic [1:0] c);
    return {s, e, g, r, st, z, c};
  endfunction

  // driver: present one operand and wait (bounded) for it to be taken
  task automatic drive_op(input logic [47:0] s, input logic [8:0] e, input logic g,
                          input logic r, input logic st, input logic [5:0] lza,
                          input string tag, output int waited);
    in_sum = s; in_exp = e; in_guard = g; in_round = r; in_sticky = st; in_lza = lza;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({tag, "_accept"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // scoreboard side: wait for out_valid, compare against the queued expectation,
  // optionally stall for hold cycles, then complete the output handshake
  task automatic expect_result(input int lat, input int hold, input string tag);
    int cyc;
    logic [62:0] w;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    w = exp_q.pop_front();
    check({tag, "_sum"},  64'(out_sum), 64'(w[62:15]));
    check({tag, "_exp"},  64'(out_exp), 64'(w[14:6]));
    check({tag, "_grs"},  64'({out_guard, out_round, out_sticky}), 64'(w[5:3]));
    check({tag, "_zero"}, 64'(out_zero), 64'(w[2]));
    check({tag, "_corr"}, 64'(out_corr), 64'(w[1:0]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_out"}, {15'd0, out_valid, out_sum}, {15'd0, 1'b1, w[62:15]});
      check({tag, "_hold_meta"}, 64'({out_exp, out_guard, out_round, out_sticky, out_zero, out_corr}),
            64'(w[14:0]));
      check({tag, "_hold_inrdy"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_post_inrdy"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [47:0] s, input logic [8:0] e, input logic g,
                        input logic r, input logic st, input logic [5:0] lza,
                        input logic [62:0] want, input int lat, input int hold,
                        input string tag, output int waited);
    exp_q.push_back(want);
    drive_op(s, e, g, r, st, lza, tag, waited);
    expect_result(lat, hold, tag);
  endtask

  initial begin
    int waited;
    int stale;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_sum = '0; in_exp = '0; in_guard = 0; in_round = 0; in_sticky = 0; in_lza = '0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_sum",   64'(out_sum), 64'd0);
    check("rst_exp",   64'(out_exp), 64'd0);
    check("rst_grs",   64'({out_guard, out_round, out_sticky}), 64'd0);
    check("rst_zero",  64'(out_zero), 64'd0);
    check("rst_corr",  64'(out_corr), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    check("rst_inrdy", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_rel_inrdy", 64'(in_ready), 64'd1);

    // exact prediction: leading 1 at bit 27, 20 shifts -> exp 110, lat 3+0+2
    run_op(48'h0000_0800_0000, 9'd130, 0, 0, 0, 6'd20,
           pack(48'h8000_0000_0000, 9'd110, 0, 0, 0, 0, 2'd0), 5, 0, "exact", waited);
    // under-prediction by one: one correction, lat 3+1+2
    run_op(48'h0000_0800_0000, 9'd130, 0, 0, 0, 6'd19,
           pack(48'h8000_0000_0000, 9'd110, 0, 0, 0, 0, 2'd1), 6, 0, "under1", waited);
    // guard bit rides along the shift into out_sum bit 19
    run_op(48'h0000_0800_0000, 9'd130, 1, 0, 0, 6'd20,
           pack(48'h8000_0008_0000, 9'd110, 0, 0, 0, 0, 2'd0), 5, 0, "gshift", waited);
    // leading 1 at sum[0] with G,R set: three bits end up at sum[47:45]
    run_op(48'h0000_0000_0001, 9'd60, 1, 1, 1, 6'd47,
           pack(48'hE000_0000_0000, 9'd13, 0, 0, 1, 0, 2'd0), 8, 0, "grs_in", waited);
    // shift of 1: round lands in guard, guard in sum[0]; exp 0-1 wraps to 511
    run_op(48'h4000_0000_0000, 9'd0, 1, 1, 0, 6'd1,
           pack(48'h8000_0000_0001, 9'd511, 1, 0, 0, 0, 2'd0), 3, 0, "wrap", waited);
    // sticky-only input counts as zero
    run_op(48'h0, 9'd77, 0, 0, 1, 6'd5,
           pack(48'h0, 9'd77, 0, 0, 1, 1, 2'd0), 1, 0, "zero", waited);
    // already normalized with lza 0: straight to CHECK
    run_op(48'h8000_0000_0000, 9'd200, 1, 0, 0, 6'd0,
           pack(48'h8000_0000_0000, 9'd200, 1, 0, 0, 0, 2'd0), 2, 0, "lza0", waited);
    // four corrections: counter saturates at 3, exp drops by 4
    run_op(48'h0800_0000_0000, 9'd100, 0, 0, 0, 6'd0,
           pack(48'h8000_0000_0000, 9'd96, 0, 0, 0, 0, 2'd3), 6, 0, "corr_sat", waited);
    // lza 63 clamped to 47
    run_op(48'h0000_0000_0001, 9'd57, 0, 0, 0, 6'd63,
           pack(48'h8000_0000_0000, 9'd10, 0, 0, 0, 0, 2'd0), 8, 0, "clamp", waited);
    // only guard set, lza 0: 48 corrections
    run_op(48'h0, 9'd100, 1, 0, 0, 6'd0,
           pack(48'h8000_0000_0000, 9'd52, 0, 0, 0, 0, 2'd3), 50, 0, "gonly", waited);

    // backpressure for 4 cycles, then a queued operand must go in at once
    run_op(48'h0000_0800_0000, 9'd130, 0, 0, 0, 6'd20,
           pack(48'h8000_0000_0000, 9'd110, 0, 0, 0, 0, 2'd0), 5, 4, "bp", waited);
    run_op(48'h0000_0800_0000, 9'd130, 0, 0, 0, 6'd19,
           pack(48'h8000_0000_0000, 9'd110, 0, 0, 0, 0, 2'd1), 6, 0, "bp_next", waited);
    check("bp_next_wait", 64'(waited), 64'd0);

    // reset in cycle 2 of an lza=40 operation
    drive_op(48'h0000_0000_0100, 9'd90, 0, 0, 0, 6'd40, "mid", waited);
    @(posedge clk); #1;
    check("mid_in_pred", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_inrdy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_state", 64'(dbg_state), 64'd0);
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_busy",  64'(busy), 64'd0);
    check("mid_inrdy", 64'(in_ready), 64'd1);
    stale = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    check("mid_no_stale", 64'(stale), 64'd0);
    run_op(48'h8000_0000_0000, 9'd200, 1, 0, 0, 6'd0,
           pack(48'h8000_0000_0000, 9'd200, 1, 0, 0, 0, 2'd0), 2, 0, "recover", waited);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
